// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction memory, buffers words, feeds decode.
// Latency: grant in cycle t with rvalid in t+1 gives instruction_reg valid in t+3; redirect bubbles next cycle.
// Backpressure: imem_req drops whenever outstanding requests plus buffered words reach DEPTH.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   update_pc, new_pc     redirect from decode (target low two bits ignored)
//   imem_req, imem_addr   read request valid and word address (= fetch PC)
//   imem_gnt              request accepted this cycle when imem_req=1
//   imem_rvalid, imem_rdata  in-order response, one per grant
//   instruction_reg       {pc, instr} to decode, all zeros = bubble

// Small synchronous FIFO used for both the word buffer and the pc tag queue.
// Latency: push visible on pop_dat the next cycle; pop_dat is the head, read combinationally.
// Backpressure: push is ignored when full unless a pop happens the same cycle; clr wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// Top of the fetch stage.
// Latency: three cycles from grant to decode with single-cycle memory; sustains one word per cycle.
// Backpressure: credit based -- a request is only raised when a FIFO slot is reserved for its response.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        update_pc,
    input  logic [31:0] new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] instruction_reg
);
    localparam int               CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]      DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] drop;

    logic [63:0]   dq_head;
    logic [CW-1:0] dq_count;
    logic [31:0]   tq_head;
    logic [CW-1:0] tq_count;

    logic          grant;
    logic          keep_rsp;
    logic          dq_pop;

    // The low two bits of a redirect target are forced to zero.
    logic          unused_pc_bits;
    assign unused_pc_bits = ^new_pc[1:0];

    // Each credit covers one word from request through buffering until
    // it is handed to decode, so the FIFO can never overflow.
    assign imem_req  = ({1'b0, inflight} + {1'b0, dq_count}) < DEPTH_W;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response is kept only when nothing stale is still owed. The tag
    // queue check is defensive; with a well-behaved memory it always holds.
    assign keep_rsp  = imem_rvalid && (drop == '0) && (tq_count != '0);
    assign dq_pop    = (dq_count != '0);

    always_comb begin
        inflight_nxt = inflight;
        case ({grant, imem_rvalid})
            2'b10: inflight_nxt = inflight + CW'(1);
            2'b01: begin
                if (inflight != '0) begin
                    inflight_nxt = inflight - CW'(1);
                end
            end
            default: inflight_nxt = inflight;
        endcase
    end

    // Buffered {pc, instr} words waiting for decode.
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_data_q (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (update_pc),
        .push     (keep_rsp),
        .push_dat ({tq_head, imem_rdata}),
        .pop      (dq_pop),
        .pop_dat  (dq_head),
        .count    (dq_count)
    );

    // PCs of granted requests whose responses will be kept, in issue order.
    // A grant in the redirect cycle is stale, which clr covers.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (update_pc),
        .push     (grant),
        .push_dat (fetch_pc),
        .pop      (keep_rsp),
        .pop_dat  (tq_head),
        .count    (tq_count)
    );

    // Outstanding request count keeps counting through a redirect since the
    // memory still owes those responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_nxt;
        end
    end

    // On redirect everything still owed after this edge is stale, which is
    // exactly the updated inflight count (grant counted, rvalid consumed).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop <= '0;
        end else if (update_pc) begin
            drop <= inflight_nxt;
        end else if (imem_rvalid && (drop != '0)) begin
            drop <= drop - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
        end else if (update_pc) begin
            fetch_pc <= {new_pc[31:2], 2'b00};
        end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // No bypass from imem_rdata: words always pass through the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst || update_pc) begin
            instruction_reg <= 64'd0;
        end else if (dq_pop) begin
            instruction_reg <= dq_head;
        end else begin
            instruction_reg <= 64'd0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        update_pc;
    logic [31:0] new_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] instruction_reg;

    logic        rst2;
    logic        upd2;
    logic [31:0] npc2;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [63:0] ir2;

    int errors;
    int checks;

    always #5 i_clk = ~i_clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .update_pc       (update_pc),
        .new_pc          (new_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instruction_reg (instruction_reg)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .i_clk           (i_clk),
        .i_rst           (rst2),
        .update_pc       (upd2),
        .new_pc          (npc2),
        .imem_req        (req2),
        .imem_addr       (addr2),
        .imem_gnt        (gnt2),
        .imem_rvalid     (rvalid2),
        .imem_rdata      (rdata2),
        .instruction_reg (ir2)
    );

    function automatic logic [63:0] exp_word(input logic [31:0] pc);
        return {pc, pc ^ K};
    endfunction

    // Memory for the main DUT: in-order, fixed latency mem_lat (>=1), data = addr ^ K.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    int          mem_lat = 1;
    logic        s_req, s_gnt, s_rst;
    logic [31:0] s_addr;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(negedge i_clk);
            s_req  = imem_req;
            s_gnt  = imem_gnt;
            s_addr = imem_addr;
            s_rst  = i_rst;
            @(posedge i_clk);
            #1;
            cyc++;
            if (s_rst !== 1'b0) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (s_req === 1'b1 && s_gnt === 1'b1) begin
                pend_addr.push_back(s_addr);
                pend_due.push_back(cyc + mem_lat - 1);
            end
            if (s_rst === 1'b0 && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr[0] ^ K;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'd0;
            end
        end
    end

    // Memory for the wrap DUT: always grants, one-cycle latency.
    logic        s_req2, s_rst2;
    logic [31:0] s_addr2;

    initial begin
        rvalid2 = 1'b0;
        rdata2  = 32'd0;
        forever begin
            @(negedge i_clk);
            s_req2  = req2;
            s_addr2 = addr2;
            s_rst2  = rst2;
            @(posedge i_clk);
            #1;
            if (s_rst2 === 1'b0 && s_req2 === 1'b1) begin
                rvalid2 = 1'b1;
                rdata2  = s_addr2 ^ K;
            end else begin
                rvalid2 = 1'b0;
                rdata2  = 32'd0;
            end
        end
    end

    // Leaves the bench at the start of cycle 0 (first cycle with reset low).
    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        update_pc = 1'b0;
        imem_gnt = 1'b1;
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (instruction_reg !== 64'd0) begin
            errors++; $display("FAIL reset_ir: got %h expected %h", instruction_reg, 64'd0);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0);
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_req: got %b expected 1", imem_req);
        end
    endtask

    task automatic test_stream();
        logic [63:0] expv;
        mem_lat = 1;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(negedge i_clk);
            expv = (k < 3) ? 64'd0 : exp_word(32'(4 * (k - 3)));
            checks++;
            if (instruction_reg !== expv) begin
                errors++; $display("FAIL stream_ir c%0d: got %h expected %h", k, instruction_reg, expv);
            end
            checks++;
            if (imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr c%0d: got %h expected %h", k, imem_addr, 32'(4 * k));
            end
            checks++;
            if (imem_req !== 1'b1) begin
                errors++; $display("FAIL stream_req c%0d: got %b expected 1", k, imem_req);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int n;
        mem_lat = 3;
        do_reset();
        exp_pc = 32'd0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (k == 3) begin
                checks++;
                if (imem_req !== 1'b1) begin
                    errors++; $display("FAIL bp_req_c3: got %b expected 1", imem_req);
                end
            end
            if (k == 4) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++; $display("FAIL bp_req_c4: got %b expected 0", imem_req);
                end
            end
            if (k == 5) begin
                checks++;
                if (instruction_reg !== exp_word(32'd0)) begin
                    errors++; $display("FAIL bp_first c5: got %h expected %h", instruction_reg, exp_word(32'd0));
                end
            end
            if (instruction_reg !== 64'd0) begin
                checks++;
                if (instruction_reg !== exp_word(exp_pc)) begin
                    errors++; $display("FAIL bp_stream c%0d: got %h expected %h", k, instruction_reg, exp_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++;
        if (n < 24) begin
            errors++; $display("FAIL bp_count: got %0d words expected at least 24", n);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        mem_lat = 3;
        do_reset();
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        // cycle 2: two requests in flight, hold off a third, redirect
        imem_gnt  = 1'b0;
        update_pc = 1'b1;
        new_pc    = 32'h0000_0103;
        @(posedge i_clk); #1;
        imem_gnt  = 1'b1;
        update_pc = 1'b0;
        @(negedge i_clk);
        checks++;
        if (imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL redir_addr: got %h expected %h", imem_addr, 32'h0000_0100);
        end
        checks++;
        if (instruction_reg !== 64'd0) begin
            errors++; $display("FAIL redir_bubble: got %h expected %h", instruction_reg, 64'd0);
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL redir_req: got %b expected 1", imem_req);
        end
        exp_pc = 32'h0000_0104;
        for (int k = 4; k <= 24; k++) begin
            @(negedge i_clk);
            if (k < 8) begin
                checks++;
                if (instruction_reg !== 64'd0) begin
                    errors++; $display("FAIL redir_stale c%0d: got %h expected %h", k, instruction_reg, 64'd0);
                end
            end else if (k == 8) begin
                checks++;
                if (instruction_reg !== exp_word(32'h100)) begin
                    errors++; $display("FAIL redir_first c8: got %h expected %h", instruction_reg, exp_word(32'h100));
                end
            end else if (instruction_reg !== 64'd0) begin
                checks++;
                if (instruction_reg !== exp_word(exp_pc)) begin
                    errors++; $display("FAIL redir_stream c%0d: got %h expected %h", k, instruction_reg, exp_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic test_redirect_same();
        logic [63:0] expv;
        mem_lat = 1;
        do_reset();
        repeat (5) begin
            @(posedge i_clk); #1;
        end
        // cycle 5: grant and rvalid both active, redirect
        update_pc = 1'b1;
        new_pc    = 32'h0000_0200;
        @(negedge i_clk);
        checks++;
        if (instruction_reg !== exp_word(32'd8)) begin
            errors++; $display("FAIL same_pre c5: got %h expected %h", instruction_reg, exp_word(32'd8));
        end
        @(posedge i_clk); #1;
        update_pc = 1'b0;
        @(negedge i_clk);
        checks++;
        if (imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL same_addr c6: got %h expected %h", imem_addr, 32'h0000_0200);
        end
        for (int k = 6; k <= 10; k++) begin
            if (k > 6) @(negedge i_clk);
            expv = (k < 9) ? 64'd0 : exp_word(32'h200 + 32'(4 * (k - 9)));
            checks++;
            if (instruction_reg !== expv) begin
                errors++; $display("FAIL same_ir c%0d: got %h expected %h", k, instruction_reg, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] expv;
        mem_lat = 3;
        do_reset();
        repeat (10) begin
            @(posedge i_clk); #1;
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (instruction_reg !== 64'd0) begin
            errors++; $display("FAIL mid_ir: got %h expected %h", instruction_reg, 64'd0);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_addr: got %h expected %h", imem_addr, 32'h0);
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL mid_req: got %b expected 1", imem_req);
        end
        for (int k = 12; k <= 16; k++) begin
            @(negedge i_clk);
            expv = (k < 16) ? 64'd0 : exp_word(32'd0);
            checks++;
            if (instruction_reg !== expv) begin
                errors++; $display("FAIL mid_restart c%0d: got %h expected %h", k, instruction_reg, expv);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] expv;
        @(posedge i_clk); #1;
        rst2 = 1'b1;
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        rst2 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge i_clk);
            case (k)
                3:       expv = exp_word(32'hFFFF_FFF8);
                4:       expv = exp_word(32'hFFFF_FFFC);
                5:       expv = exp_word(32'h0000_0000);
                default: expv = 64'd0;
            endcase
            checks++;
            if (ir2 !== expv) begin
                errors++; $display("FAIL wrap_ir c%0d: got %h expected %h", k, ir2, expv);
            end
            if (k == 2) begin
                checks++;
                if (addr2 !== 32'h0) begin
                    errors++; $display("FAIL wrap_addr c2: got %h expected %h", addr2, 32'h0);
                end
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        i_rst     = 1'b1;
        update_pc = 1'b0;
        new_pc    = 32'd0;
        imem_gnt  = 1'b1;
        rst2      = 1'b1;
        upd2      = 1'b0;
        npc2      = 32'd0;
        gnt2      = 1'b1;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same();
        test_reset_mid();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
